// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO router: FSM state encoding, error data,
// default peripheral window base and the slot map used by the game build.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    P_WAIT  = 2'd1,
    WB_WAIT = 2'd2,
    RESP    = 2'd3
  } mmio_state_t;

  localparam logic [31:0] ERR_DATA            = 32'hDEAD_BEEF;
  localparam logic [31:0] DEFAULT_PERIPH_BASE = 32'hFF00_0000;

  // Slot assignment for the game build
  localparam int SLOT_NES        = 0;
  localparam int SLOT_DPU_STATE  = 1;
  localparam int SLOT_DPU_POS    = 2;
  localparam int SLOT_HW_COUNTER = 3;

  // Width of a slot index; a single-slot window still needs one bit
  function automatic int slot_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_router_if.sv
// Bus bundle for mmio_router: CPU load/store port, peripheral slot window and
// Wishbone RAM path. The router uses the master modport, the environment the slave.
interface mmio_router_if #(
  parameter int NUM_PERIPH = 4,
  parameter int DATA_W     = 32
);
  // Handshake: every request (cpu_ren/cpu_wen, p_req, wb_ren/wb_wen) is a level held
  // from acceptance until the edge that samples its ack; ack is a completion strobe,
  // and the requester must drop the level in the cycle after seeing it.
  logic [31:0]                  cpu_addr;
  logic [DATA_W-1:0]            cpu_din;
  logic [3:0]                   cpu_sel;
  logic                         cpu_ren;
  logic                         cpu_wen;
  logic [DATA_W-1:0]            cpu_do;
  logic                         cpu_ack;
  logic                         cpu_err;

  logic [NUM_PERIPH-1:0]        p_req;
  logic                         p_we;
  logic [DATA_W-1:0]            p_wdata;
  logic [NUM_PERIPH*DATA_W-1:0] p_rdata;
  logic [NUM_PERIPH-1:0]        p_ack;

  logic [31:0]                  wb_addro;
  logic [DATA_W-1:0]            wb_do;
  logic [3:0]                   wb_sel;
  logic                         wb_ren;
  logic                         wb_wen;
  logic [DATA_W-1:0]            wb_di;
  logic                         wb_ack;

  modport master (
    input  cpu_addr, cpu_din, cpu_sel, cpu_ren, cpu_wen,
    output cpu_do, cpu_ack, cpu_err,
    output p_req, p_we, p_wdata,
    input  p_rdata, p_ack,
    output wb_addro, wb_do, wb_sel, wb_ren, wb_wen,
    input  wb_di, wb_ack
  );

  modport slave (
    output cpu_addr, cpu_din, cpu_sel, cpu_ren, cpu_wen,
    input  cpu_do, cpu_ack, cpu_err,
    input  p_req, p_we, p_wdata,
    output p_rdata, p_ack,
    input  wb_addro, wb_do, wb_sel, wb_ren, wb_wen,
    output wb_di, wb_ack
  );

endinterface

// File: rtl/mmio_addr_decode.sv
// Combinational decode of a CPU address into peripheral-window hit, slot index
// and misalignment flag. Slots sit at PERIPH_BASE + 4*k.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int          NUM_PERIPH  = 4,
  parameter logic [31:0] PERIPH_BASE = DEFAULT_PERIPH_BASE
) (
  input  logic [31:0]                        addr,
  output logic                               hit,
  output logic [slot_bits(NUM_PERIPH)-1:0]   slot,
  output logic                               misaligned
);

  localparam int SLOT_W = slot_bits(NUM_PERIPH);

  logic [32:0] limit;

  // 33-bit compare so a window ending at the top of the address space cannot wrap
  assign limit      = {1'b0, PERIPH_BASE} + 33'(4 * NUM_PERIPH);
  assign hit        = ({1'b0, addr} >= {1'b0, PERIPH_BASE}) && ({1'b0, addr} < limit);
  assign slot       = addr[SLOT_W+1:2] - PERIPH_BASE[SLOT_W+1:2];
  assign misaligned = hit && (addr[1:0] != 2'b00);

endmodule

// File: rtl/mmio_router.sv
// MMIO router: one registered request/ack FSM steering CPU accesses to a peripheral
// slot or the Wishbone RAM path. Define MMIO_TIMEOUT_EN to add the wait watchdog.
module mmio_router
  import mmio_pkg::*;
#(
  parameter int          NUM_PERIPH  = 4,
  parameter logic [31:0] PERIPH_BASE = DEFAULT_PERIPH_BASE,
  parameter int          DATA_W      = 32,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  mmio_router_if.master bus,
  output mmio_state_t   dbg_state
);

  localparam int SLOT_W = slot_bits(NUM_PERIPH);

  mmio_state_t       state;
  logic [SLOT_W-1:0] slot_q;
  logic              we_q;

  logic              dec_hit;
  logic [SLOT_W-1:0] dec_slot;
  logic              dec_misaligned;
  logic              p_ack_sel;
  logic [DATA_W-1:0] p_rdata_sel;
  logic              timeout;

  mmio_addr_decode #(
    .NUM_PERIPH (NUM_PERIPH),
    .PERIPH_BASE(PERIPH_BASE)
  ) u_decode (
    .addr      (bus.cpu_addr),
    .hit       (dec_hit),
    .slot      (dec_slot),
    .misaligned(dec_misaligned)
  );

  assign p_ack_sel   = bus.p_ack[slot_q];
  assign p_rdata_sel = bus.p_rdata[int'(slot_q)*DATA_W +: DATA_W];
  assign dbg_state   = state;

`ifdef MMIO_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // Zero whenever not waiting, so it is already clear on entry to a wait state
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state == RESP) wait_cnt <= '0;
    else                                       wait_cnt <= wait_cnt + 16'd1;
  end

  assign timeout = (wait_cnt + 16'd1) == 16'(TIMEOUT_CYC);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      slot_q       <= '0;
      we_q         <= 1'b0;
      bus.cpu_do   <= '0;
      bus.cpu_ack  <= 1'b0;
      bus.cpu_err  <= 1'b0;
      bus.p_req    <= '0;
      bus.p_we     <= 1'b0;
      bus.p_wdata  <= '0;
      bus.wb_addro <= '0;
      bus.wb_do    <= '0;
      bus.wb_sel   <= '0;
      bus.wb_ren   <= 1'b0;
      bus.wb_wen   <= 1'b0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.cpu_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_ren || bus.cpu_wen) begin
            we_q   <= bus.cpu_wen;
            slot_q <= dec_slot;
            if (dec_misaligned) begin
              state       <= RESP;
              bus.cpu_ack <= 1'b1;
              bus.cpu_err <= 1'b1;
              bus.cpu_do  <= DATA_W'(ERR_DATA);
            end else if (dec_hit) begin
              state       <= P_WAIT;
              bus.p_req   <= NUM_PERIPH'(1) << dec_slot;
              bus.p_we    <= bus.cpu_wen;
              bus.p_wdata <= bus.cpu_din;
            end else begin
              // Write wins when both request levels are high
              state        <= WB_WAIT;
              bus.wb_addro <= bus.cpu_addr;
              bus.wb_do    <= bus.cpu_din;
              bus.wb_sel   <= bus.cpu_sel;
              bus.wb_ren   <= ~bus.cpu_wen;
              bus.wb_wen   <= bus.cpu_wen;
            end
          end
        end
        P_WAIT: begin
          if (p_ack_sel || timeout) begin
            state       <= RESP;
            bus.cpu_ack <= 1'b1;
            bus.p_req   <= '0;
            bus.p_we    <= 1'b0;
            bus.p_wdata <= '0;
            if (p_ack_sel) begin
              bus.cpu_do <= we_q ? '0 : p_rdata_sel;
            end else begin
              bus.cpu_err <= 1'b1;
              bus.cpu_do  <= DATA_W'(ERR_DATA);
            end
          end
        end
        WB_WAIT: begin
          if (bus.wb_ack || timeout) begin
            state        <= RESP;
            bus.cpu_ack  <= 1'b1;
            bus.wb_addro <= '0;
            bus.wb_do    <= '0;
            bus.wb_sel   <= '0;
            bus.wb_ren   <= 1'b0;
            bus.wb_wen   <= 1'b0;
            if (bus.wb_ack) begin
              bus.cpu_do <= bus.wb_di;
            end else begin
              bus.cpu_err <= 1'b1;
              bus.cpu_do  <= DATA_W'(ERR_DATA);
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router: slot, Wishbone, misaligned, watchdog/unbounded wait
// and reset-abandon cases, with hand-computed expected values.
module tb_mmio_router;
  import mmio_pkg::*;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  mmio_state_t dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic        p_seen, wb_seen, ack_seen;

  mmio_router_if #(.NUM_PERIPH(NP), .DATA_W(DW)) bus ();

  mmio_router #(
    .NUM_PERIPH (NP),
    .PERIPH_BASE(32'hFF00_0000),
    .DATA_W     (DW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: got simulation still running expected finished");
    $fatal(1, "bench time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.p_req != '0)          p_seen   = 1'b1;
    if (bus.wb_ren || bus.wb_wen) wb_seen  = 1'b1;
    if (bus.cpu_ack)              ack_seen = 1'b1;
  endtask

  // Present a request and take the acceptance edge E0
  task automatic start(input logic [31:0] addr, input logic [31:0] din,
                       input logic [3:0] sel, input logic ren, input logic wen);
    bus.cpu_addr = addr;
    bus.cpu_din  = din;
    bus.cpu_sel  = sel;
    bus.cpu_ren  = ren;
    bus.cpu_wen  = wen;
    p_seen   = 1'b0;
    wb_seen  = 1'b0;
    ack_seen = 1'b0;
    step();
  endtask

  task automatic check_resp(input string tag, input logic err);
    logic [DW-1:0] exp_do;
    exp_do = exp_q.pop_front();
    check({tag, "_ack"}, 32'(bus.cpu_ack), 32'd1);
    check({tag, "_err"}, 32'(bus.cpu_err), 32'(err));
    check({tag, "_do"},  bus.cpu_do, exp_do);
  endtask

  // Leave RESP with the request still held, then drop it and confirm no re-accept
  task automatic finish_access(input string tag);
    step();
    check({tag, "_ack_pulse"}, 32'(bus.cpu_ack), 32'd0);
    check({tag, "_idle"}, 32'(dbg_state), 32'(IDLE));
    bus.cpu_ren = 1'b0;
    bus.cpu_wen = 1'b0;
    bus.p_ack   = '0;
    bus.wb_ack  = 1'b0;
    step();
    check({tag, "_no_reaccept"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    bus.cpu_addr = '0;
    bus.cpu_din  = '0;
    bus.cpu_sel  = '0;
    bus.cpu_ren  = 1'b0;
    bus.cpu_wen  = 1'b0;
    bus.p_rdata  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_00A5};
    bus.p_ack    = '0;
    bus.wb_di    = '0;
    bus.wb_ack   = 1'b0;
    p_seen = 1'b0; wb_seen = 1'b0; ack_seen = 1'b0;

    // reset state
    rst = 1'b1;
    step();
    step();
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_p", {27'd0, bus.p_req, bus.p_we}, 32'd0);
    check("rst_p_wdata", bus.p_wdata, 32'd0);
    check("rst_wb_addro", bus.wb_addro, 32'd0);
    check("rst_wb_do", bus.wb_do, 32'd0);
    check("rst_wb_ctl", {26'd0, bus.wb_sel, bus.wb_ren, bus.wb_wen}, 32'd0);
    check("rst_cpu", {30'd0, bus.cpu_ack, bus.cpu_err}, 32'd0);
    check("rst_cpu_do", bus.cpu_do, 32'd0);
    rst = 1'b0;
    step();

    // slot 0 read, ack sampled 3 edges after acceptance; other-slot acks ignored
    start(32'hFF00_0000, 32'd0, 4'hF, 1'b1, 1'b0);
    check("s0_p_req", 32'(bus.p_req), 32'b0001);
    check("s0_p_we", 32'(bus.p_we), 32'd0);
    check("s0_state", 32'(dbg_state), 32'(P_WAIT));
    bus.p_ack = 4'b1110;
    step();
    step();
    check("s0_wait_ack", 32'(ack_seen), 32'd0);
    check("s0_wait_req", 32'(bus.p_req), 32'b0001);
    bus.p_ack = 4'b0001;
    step();
    exp_q.push_back(32'h0000_00A5);
    check_resp("s0", 1'b0);
    check("s0_req_drop", 32'(bus.p_req), 32'd0);
    finish_access("s0");
    check("s0_no_wb", 32'(wb_seen), 32'd0);

    // slot 1 write, ack tied high
    bus.p_ack = 4'b0010;
    start(32'hFF00_0004, 32'h1234_5678, 4'hF, 1'b0, 1'b1);
    check("s1_p_req", 32'(bus.p_req), 32'b0010);
    check("s1_p_we", 32'(bus.p_we), 32'd1);
    check("s1_p_wdata", bus.p_wdata, 32'h1234_5678);
    step();
    exp_q.push_back(32'd0);
    check_resp("s1", 1'b0);
    check("s1_drop", {27'd0, bus.p_req, bus.p_we}, 32'd0);
    finish_access("s1");

    // Wishbone read, ack after 2 edges
    bus.wb_di = 32'hCAFE_F00D;
    start(32'h0000_0100, 32'd0, 4'b0110, 1'b1, 1'b0);
    check("wb_addro", bus.wb_addro, 32'h0000_0100);
    check("wb_sel", 32'(bus.wb_sel), 32'b0110);
    check("wb_rw", {30'd0, bus.wb_ren, bus.wb_wen}, 32'b10);
    step();
    check("wb_wait_ack", 32'(bus.cpu_ack), 32'd0);
    bus.wb_ack = 1'b1;
    step();
    exp_q.push_back(32'hCAFE_F00D);
    check_resp("wb_rd", 1'b0);
    check("wb_rd_drop", 32'(bus.wb_ren), 32'd0);
    finish_access("wb_rd");
    check("wb_no_p", 32'(p_seen), 32'd0);

    // one past the window, ren and wen both high: Wishbone write
    bus.wb_ack = 1'b1;
    bus.wb_di  = 32'h0000_55AA;
    start(32'hFF00_0010, 32'hA5A5_0F0F, 4'hF, 1'b1, 1'b1);
    check("edge_wb_rw", {30'd0, bus.wb_ren, bus.wb_wen}, 32'b01);
    check("edge_wb_do", bus.wb_do, 32'hA5A5_0F0F);
    check("edge_no_p", 32'(bus.p_req), 32'd0);
    step();
    exp_q.push_back(32'h0000_55AA);
    check_resp("edge", 1'b0);
    finish_access("edge");

    // misaligned slot access
    start(32'hFF00_0006, 32'd0, 4'hF, 1'b1, 1'b0);
    exp_q.push_back(32'hDEAD_BEEF);
    check_resp("mis", 1'b1);
    check("mis_state", 32'(dbg_state), 32'(RESP));
    finish_access("mis");
    check("mis_no_req", {30'd0, p_seen, wb_seen}, 32'd0);

`ifdef MMIO_TIMEOUT_EN
    // watchdog: no ack aborts after TO wait edges
    start(32'hFF00_000C, 32'd0, 4'hF, 1'b1, 1'b0);
    check("to_p_req", 32'(bus.p_req), 32'b1000);
    for (int i = 1; i < TO; i++) step();
    check("to_no_early_ack", 32'(ack_seen), 32'd0);
    check("to_req_held", 32'(bus.p_req), 32'b1000);
    step();
    exp_q.push_back(32'hDEAD_BEEF);
    check_resp("to", 1'b1);
    check("to_req_drop", 32'(bus.p_req), 32'd0);
    finish_access("to");

    // ack on the final wait edge wins over the watchdog
    start(32'hFF00_000C, 32'd0, 4'hF, 1'b1, 1'b0);
    for (int i = 1; i < TO; i++) step();
    bus.p_ack = 4'b1000;
    step();
    exp_q.push_back(32'h3333_3333);
    check_resp("to_race", 1'b0);
    finish_access("to_race");
`else
    // without the watchdog a wait longer than TIMEOUT_CYC still completes
    start(32'hFF00_000C, 32'd0, 4'hF, 1'b1, 1'b0);
    for (int i = 1; i < 12; i++) step();
    check("long_no_ack", 32'(ack_seen), 32'd0);
    check("long_state", 32'(dbg_state), 32'(P_WAIT));
    check("long_req", 32'(bus.p_req), 32'b1000);
    bus.p_ack = 4'b1000;
    step();
    exp_q.push_back(32'h3333_3333);
    check_resp("long", 1'b0);
    finish_access("long");
`endif

    // reset during WB_WAIT abandons the access
    bus.wb_ack = 1'b0;
    start(32'h0000_0200, 32'd0, 4'hF, 1'b1, 1'b0);
    check("ra_wb_ren", 32'(bus.wb_ren), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.cpu_ren = 1'b0;
    check("ra_state", 32'(dbg_state), 32'(IDLE));
    check("ra_wb", {26'd0, bus.wb_sel, bus.wb_ren, bus.wb_wen}, 32'd0);
    check("ra_wb_addro", bus.wb_addro, 32'd0);
    check("ra_cpu", {30'd0, bus.cpu_ack, bus.cpu_err}, 32'd0);
    check("ra_cpu_do", bus.cpu_do, 32'd0);
    ack_seen   = 1'b0;
    bus.wb_ack = 1'b1;
    step();
    step();
    step();
    check("ra_no_ack", 32'(ack_seen), 32'd0);
    bus.wb_ack = 1'b0;

    // first access after reset completes normally
    bus.p_ack = 4'b0100;
    start(32'hFF00_0008, 32'd0, 4'hF, 1'b1, 1'b0);
    check("post_p_req", 32'(bus.p_req), 32'b0100);
    step();
    exp_q.push_back(32'h2222_2222);
    check_resp("post", 1'b0);
    finish_access("post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmio_router.md
# mmio_router

Parametrised memory-mapped I/O router between the CPU load/store port, a window of N handshaked peripheral slots, and the Wishbone RAM path. Every CPU access goes through a registered request/acknowledge FSM. Each slot is decoded from a base address and a 4-byte stride, so the NES controller, DPU registers, hardware counter and future devices are all one slot type. An optional watchdog terminates accesses that are never acknowledged.

## Interface
Parameters:
- NUM_PERIPH, 4, number of peripheral slots (1..16)
- PERIPH_BASE, 32'hFF00_0000, address of slot 0; slot k is at PERIPH_BASE + 4*k
- DATA_W, 32, data width; address width is fixed at 32
- TIMEOUT_CYC, 255, wait cycles before watchdog abort (1..65535)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- cpu_addr  in  32  access address, held until cpu_ack
- cpu_din  in  DATA_W  write data
- cpu_sel  in  4  byte enables
- cpu_ren, cpu_wen  in  1  request levels, held until cpu_ack
- cpu_do  out  DATA_W  read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle pulse with cpu_ack on a misaligned or timed-out access
- p_req  out  NUM_PERIPH  one-hot slot request level
- p_we  out  1  1 = write to the slot
- p_wdata  out  DATA_W  write data to the slot
- p_rdata  in  NUM_PERIPH*DATA_W  slot read data, flattened, slot 0 in the LSBs
- p_ack  in  NUM_PERIPH  slot acknowledge
- wb_addro, wb_do  out  32/DATA_W  Wishbone address and write data
- wb_sel  out  4  Wishbone byte enables
- wb_ren, wb_wen  out  1  Wishbone request levels
- wb_di  in  DATA_W  Wishbone read data
- wb_ack  in  1  Wishbone acknowledge

## Operation
- States: IDLE, P_WAIT, WB_WAIT, RESP.
- IDLE:
  - on (cpu_ren|cpu_wen), latch addr, din, sel and write flag.
  - If cpu_wen and cpu_ren are both high, the access is a write.
- Decode:
  - hit when PERIPH_BASE <= addr < PERIPH_BASE + 4*NUM_PERIPH; slot = (addr-PERIPH_BASE)>>2.
  - A hit with addr[1:0] != 0 goes straight to RESP with error, and no request is issued.
  - Any other hit goes to P_WAIT. A miss goes to WB_WAIT.
- P_WAIT:
  - p_req[slot]=1, p_we and p_wdata driven from the latches.
  - When p_ack[slot]=1, capture p_rdata[slot] (writes capture 0) and go to RESP.
  - Acks from other slots are ignored.
- WB_WAIT:
  - wb_* driven from the latches.
  - When wb_ack=1, capture wb_di and go to RESP.
- RESP: cpu_ack=1, cpu_do = captured data, then go to IDLE.
- cpu_do holds its last value until the next RESP.
- The error response returns data 32'hDEAD_BEEF with cpu_err=1.
- Reset values:
  - state IDLE.
  - All of p_req, p_we, p_wdata, wb_* (including wb_sel), cpu_ack, cpu_err, cpu_do = 0.
- Reset during a wait abandons the access: requests drop at the reset edge and no cpu_ack is issued.

## Timing
- Every output is registered.
- Request is accepted at edge E0; p_req or wb_ren/wb_wen are high from E0.
- An ack sampled high at edge Ek gives cpu_ack high during cycle k+1.
- With an ack tied high, cpu_ack comes 2 cycles after acceptance. A misaligned hit gives cpu_ack 1 cycle after acceptance.
- The CPU must drop ren/wen in the cycle after cpu_ack. IDLE ignores requests during the RESP cycle, so back-to-back accesses are spaced at least 3 cycles apart.
- Requests are level signals, held from acceptance until the ack edge inclusive, and deasserted in RESP.

## Configuration
- MMIO_TIMEOUT_EN defined:
  - A 16-bit wait counter clears on entry to P_WAIT/WB_WAIT and increments each wait cycle.
  - When the counter reaches TIMEOUT_CYC with no ack, drop the request and go to RESP with error data and cpu_err=1.
  - An ack in the same cycle as the timeout wins, and the response is normal.
- MMIO_TIMEOUT_EN undefined: no counter, waits are unbounded, and cpu_err is raised only for misaligned accesses.

## Structure
- Package mmio_pkg holds:
  - state enum mmio_state_t
  - ERR_DATA = 32'hDEAD_BEEF
  - the default PERIPH_BASE
  - the slot map for the game build: 0 NES, 1 DPU state, 2 DPU position, 3 hardware counter
- Sub-module mmio_addr_decode: combinational address to {hit, slot index, misaligned}, parametrised by NUM_PERIPH and PERIPH_BASE.

## Test plan
- Read slot 0 (0xFF00_0000) with p_ack[0] raised 3 cycles after p_req and p_rdata[0]=0x0000_00A5 -> one cpu_ack pulse with cpu_do=0xA5; wb_ren stays 0 throughout.
- Write 0x1234_5678 to slot 1 with p_ack[1] tied high -> p_req=0b0010, p_we=1 for one cycle; cpu_ack 2 cycles after acceptance.
- Read 0x0000_0100 with wb_ack after 2 cycles and wb_di=0xCAFE_F00D -> wb_addro=0x100, wb_sel=cpu_sel, cpu_do=0xCAFE_F00D; p_req stays 0.
- Read 0xFF00_0006 -> no request issued; cpu_ack and cpu_err next cycle with cpu_do=0xDEAD_BEEF.
- With MMIO_TIMEOUT_EN and TIMEOUT_CYC=8, read slot 3 with p_ack held low -> request drops and cpu_err/cpu_ack pulse 8 wait cycles later. A repeat with p_ack[3] rising on the 8th cycle gives a normal response.
- rst asserted during WB_WAIT -> all outputs 0 at the next edge and no cpu_ack; a new read after reset completes normally.
